data_bus_bridge: RTL

Bridges the processor's data port (DataAddr/DataOut/ReadData/WriteData → DataIn/DataWaitreq) to a handshaked data memory and a small memory-mapped I/O space. It sits directly downstream of the Memory stage. It decodes the address, runs a request/acknowledge FSM toward memory with a timeout, and drives DataWaitreq so the pipeline stalls at Memory until each access completes.

---
 rtl/data_bus_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: processor data port to a req/ack data memory plus LED/switch I/O.
// Optional macro DATA_BUS_WRITE_BUFFER_EN compiles in a one-entry posted write buffer.
module data_bus_bridge #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 15,
  parameter int LED_BITS  = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic [LED_BITS-1:0]  SW,
  output logic [LED_BITS-1:0]  LEDR,
  output logic                 bus_err
);

  localparam int                   CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]           LED_REGION   = 4'h1;
  localparam logic [3:0]           SW_REGION    = 4'h3;
  localparam logic [WORD_SIZE-1:0] TIMEOUT_DATA = WORD_SIZE'(16'hDEAD);

`ifdef DATA_BUS_WRITE_BUFFER_EN
  localparam logic POSTED_WRITES = 1'b1;
`else
  localparam logic POSTED_WRITES = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 mem_req_r;
  logic                 mem_we_r;
  logic [WORD_SIZE-1:0] mem_addr_r;
  logic [WORD_SIZE-1:0] mem_wdata_r;
  logic [WORD_SIZE-1:0] rdata_r;
  logic [LED_BITS-1:0]  led_r;
  logic                 bus_err_r;

  logic [3:0]           region_s;
  logic                 led_sel_s;
  logic                 sw_sel_s;
  logic                 mem_sel_s;
  logic                 access_s;
  logic                 is_write_s;
  logic                 mem_start_s;
  logic                 req_end_s;
  logic                 drain_s;
  logic                 waitreq_s;
  logic [WORD_SIZE-1:0] data_in_s;

  assign region_s    = DataAddr[WORD_SIZE-1 -: 4];
  assign led_sel_s   = (region_s == LED_REGION);
  assign sw_sel_s    = (region_s == SW_REGION);
  assign mem_sel_s   = !led_sel_s && !sw_sel_s;
  assign access_s    = ReadData || WriteData;
  assign is_write_s  = WriteData && !ReadData;
  assign mem_start_s = (state_r == ST_IDLE) && access_s && mem_sel_s;
  assign req_end_s   = (state_r == ST_REQ) && (mem_ack || (cnt_r == CNT_LAST));
  // With posted writes every write transaction in flight is a buffer drain.
  assign drain_s     = POSTED_WRITES && mem_we_r && (state_r != ST_IDLE);

  // FSM state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = mem_start_s ? ST_REQ : ST_IDLE;
      ST_REQ:  state_next_s = req_end_s ? ST_DONE : ST_REQ;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs toward the processor
  always_comb begin
    waitreq_s = 1'b0;
    data_in_s = {WORD_SIZE{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (mem_start_s) begin
          waitreq_s = !(POSTED_WRITES && is_write_s);
        end else if (ReadData && sw_sel_s) begin
          data_in_s = WORD_SIZE'(SW);
        end else if (ReadData && led_sel_s) begin
          data_in_s = WORD_SIZE'(led_r);
        end else begin
          data_in_s = {WORD_SIZE{1'b0}};
        end
      end
      ST_REQ: begin
        waitreq_s = drain_s ? access_s : 1'b1;
      end
      ST_DONE: begin
        if (drain_s) begin
          waitreq_s = access_s;
        end else if (!mem_we_r) begin
          data_in_s = rdata_r;
        end else begin
          data_in_s = {WORD_SIZE{1'b0}};
        end
      end
      default: begin
        waitreq_s = 1'b0;
        data_in_s = {WORD_SIZE{1'b0}};
      end
    endcase
  end

  // Memory request, timeout counter, captured read data and sticky error
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {WORD_SIZE{1'b0}};
      mem_wdata_r <= {WORD_SIZE{1'b0}};
      rdata_r     <= {WORD_SIZE{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      bus_err_r   <= 1'b0;
    end else if (mem_start_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= is_write_s;
      mem_addr_r  <= DataAddr;
      mem_wdata_r <= DataOut;
      cnt_r       <= {CNT_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      if (mem_ack) begin
        rdata_r   <= mem_rdata;
        mem_req_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
        rdata_r   <= TIMEOUT_DATA;
        bus_err_r <= 1'b1;
        mem_req_r <= 1'b0;
      end else begin
        cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      mem_req_r <= 1'b0;
    end
  end

  // LED register, written only by an LED-region store accepted in IDLE
  always_ff @(posedge Clock) begin
    if (Reset) begin
      led_r <= {LED_BITS{1'b0}};
    end else if ((state_r == ST_IDLE) && is_write_s && led_sel_s) begin
      led_r <= DataOut[LED_BITS-1:0];
    end else begin
      led_r <= led_r;
    end
  end

  assign DataIn      = data_in_s;
  assign DataWaitreq = waitreq_s;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign LEDR        = led_r;
  assign bus_err     = bus_err_r;

endmodule
